// File: rtl/sdq_req_driver.sv
// sdq_req_driver: valid/ready request front-end for single-port SDQ SRAM macros.
//   Clears the array after reset, then forwards requests to the macro pins.
//   Read data returns in order on a backpressured response stream.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/we/addr/wdata   request stream (write or read)
//   rsp_valid/ready/rdata/err       in-order read response stream
//   init_done                       array clear finished
//   mem_addr_o/we_o/wd_o/ce_o       macro inputs; mem_rd_i macro rd_out
// Option: define SDQ_DRV_BOUNDS_CHECK_EN to block addresses >= WORD_DEPTH
//   and return rsp_err=1 for reads to them.
module sdq_req_driver #(
  parameter int BITS       = 16,
  parameter int WORD_DEPTH = 2,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [BITS-1:0]       mem_wd_o,
  output logic                  mem_ce_o,
  input  logic [BITS-1:0]       mem_rd_i
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  infl_q, infl_d, infl_err_q, infl_err_d;
  logic [1:0][BITS-1:0]  dat_q, dat_d;
  logic [1:0]            err_q, err_d;
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            count_q, count_d;
  logic                  run, pop, accept, oob, fwd, rd;
  logic [2:0]            occ;

  always_comb begin
    run = state_q == S_RUN;
    pop = rsp_valid && rsp_ready;
    // Credit: queued + in-flight reads, minus the one leaving this cycle.
    occ = {1'b0, count_q} + {2'b0, infl_q} - {2'b0, pop};
    req_ready = run && occ < 3'd2;
    accept = req_valid && req_ready;
`ifdef SDQ_DRV_BOUNDS_CHECK_EN
    oob = {1'b0, req_addr} >= DEPTH;
`else
    oob = 1'b0;
`endif
    fwd = accept && !oob;
    rd = accept && !req_we;
    // Pins are gated by rst_n so the macro stays idle while reset is held.
    mem_ce_o = rst_n && (run ? fwd : 1'b1);
    mem_we_o = rst_n && (run ? fwd && req_we : 1'b1);
    mem_addr_o = run ? req_addr : cnt_q;
    mem_wd_o = run ? req_wdata : '0;
    state_d = (run || cnt_q == LAST) ? S_RUN : S_INIT;
    cnt_d = run ? cnt_q : cnt_q + 1'b1;
    infl_d = rd;
    infl_err_d = rd && oob;
    // rd_out is only valid the cycle after the read, so capture it then.
    dat_d = dat_q;
    err_d = err_q;
    if (infl_q) begin
      dat_d[wptr_q] = infl_err_q ? '0 : mem_rd_i;
      err_d[wptr_q] = infl_err_q;
    end
    wptr_d = wptr_q ^ infl_q;
    rptr_d = rptr_q ^ pop;
    count_d = count_q + {1'b0, infl_q} - {1'b0, pop};
    rsp_valid = count_q != 2'd0;
    rsp_rdata = dat_q[rptr_q];
    rsp_err = err_q[rptr_q];
    init_done = run;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      infl_q     <= 1'b0;
      infl_err_q <= 1'b0;
      dat_q      <= '0;
      err_q      <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
      infl_err_q <= infl_err_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_sdq_req_driver.sv
// tb_sdq_req_driver: directed self-checking bench for sdq_req_driver with a macro model.
module tb_sdq_req_driver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, init_done;
  logic [15:0] rsp_rdata;
  logic [4:0]  mem_addr_o;
  logic        mem_we_o, mem_ce_o;
  logic [15:0] mem_wd_o, mem_rd;
  logic [15:0] mem [32];
  int tests = 0;
  int fails = 0;

  sdq_req_driver #(.BITS(16), .WORD_DEPTH(2), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wd_o(mem_wd_o), .mem_ce_o(mem_ce_o), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  // Macro model: synchronous, rd_out refreshed every edge (garbage when idle).
  initial for (int i = 0; i < 32; i++) mem[i] = 16'h5555;
  always @(posedge clk) begin
    if (mem_ce_o && mem_we_o) mem[mem_addr_o] <= mem_wd_o;
    mem_rd <= mem_ce_o ? mem[mem_addr_o] : 16'hDEAD;
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++; if ({req_ready, rsp_valid, rsp_err, init_done, mem_we_o, mem_ce_o} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b exp 000000", {req_ready, rsp_valid, rsp_err, init_done, mem_we_o, mem_ce_o}); end
    tests++; if ({rsp_rdata, mem_wd_o, mem_addr_o} !== 37'b0) begin fails++; $display("FAIL reset_data got rdata=%h wd=%h addr=%h exp 0", rsp_rdata, mem_wd_o, mem_addr_o); end
    rst_n = 1'b1;
    #1;
    tests++; if ({mem_ce_o, mem_we_o, mem_addr_o, mem_wd_o, req_ready} !== {2'b11, 5'd0, 16'h0, 1'b0}) begin fails++; $display("FAIL init0 got ce=%b we=%b addr=%0d wd=%h rdy=%b exp 1 1 0 0000 0", mem_ce_o, mem_we_o, mem_addr_o, mem_wd_o, req_ready); end
    @(negedge clk); #1;
    tests++; if ({mem_ce_o, mem_we_o, mem_addr_o, init_done, req_ready} !== {2'b11, 5'd1, 2'b00}) begin fails++; $display("FAIL init1 got ce=%b we=%b addr=%0d done=%b rdy=%b exp 1 1 1 0 0", mem_ce_o, mem_we_o, mem_addr_o, init_done, req_ready); end
    @(negedge clk); #1;
    tests++; if ({init_done, req_ready, mem_ce_o, mem_we_o} !== 4'b1100) begin fails++; $display("FAIL init_done got done=%b rdy=%b ce=%b we=%b exp 1 1 0 0", init_done, req_ready, mem_ce_o, mem_we_o); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd1; req_wdata = 16'hBEEF;
    #1;
    tests++; if ({req_ready, mem_ce_o, mem_we_o} !== 3'b111) begin fails++; $display("FAIL wr_issue got rdy=%b ce=%b we=%b exp 111", req_ready, mem_ce_o, mem_we_o); end
    @(negedge clk);
    req_we = 1'b0;
    #1;
    tests++; if ({mem_ce_o, mem_we_o, mem_addr_o} !== {2'b10, 5'd1}) begin fails++; $display("FAIL rd_issue got ce=%b we=%b addr=%0d exp 1 0 1", mem_ce_o, mem_we_o, mem_addr_o); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_latency1 got rsp_valid=%b exp 0", rsp_valid); end
    @(negedge clk); #1;
    tests++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 16'hBEEF, 1'b0}) begin fails++; $display("FAIL rd_data got v=%b d=%h e=%b exp 1 beef 0", rsp_valid, rsp_rdata, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_pop got rsp_valid=%b exp 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_rdy0 got %b exp 1", req_ready); end
    @(negedge clk);
    req_addr = 5'd1;
    #1;
    tests++; if ({req_ready, mem_ce_o} !== 2'b11) begin fails++; $display("FAIL b2b_rdy1 got rdy=%b ce=%b exp 11", req_ready, mem_ce_o); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL b2b_rsp0 got v=%b d=%h exp 1 0000", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    tests++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'hBEEF}) begin fails++; $display("FAIL b2b_rsp1 got v=%b d=%h exp 1 beef", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy0 got %b exp 1", req_ready); end
    @(negedge clk);
    req_addr = 5'd0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_rdy1 got %b exp 1", req_ready); end
    @(negedge clk);
    req_addr = 5'd1;
    #1;
    tests++; if ({req_ready, mem_ce_o, rsp_valid, rsp_rdata} !== {3'b001, 16'hBEEF}) begin fails++; $display("FAIL bp_block got rdy=%b ce=%b v=%b d=%h exp 0 0 1 beef", req_ready, mem_ce_o, rsp_valid, rsp_rdata); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      tests++; if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {2'b01, 16'hBEEF, 1'b0}) begin fails++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h e=%b exp 0 1 beef 0", i, req_ready, rsp_valid, rsp_rdata, rsp_err); end
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if ({req_ready, mem_ce_o} !== 2'b11) begin fails++; $display("FAIL bp_release got rdy=%b ce=%b exp 11", req_ready, mem_ce_o); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL bp_rsp1 got v=%b d=%h exp 1 0000", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    tests++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'hBEEF}) begin fails++; $display("FAIL bp_rsp2 got v=%b d=%h exp 1 beef", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", rsp_valid); end
  endtask

  task automatic test_oob();
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
    #1;
`ifdef SDQ_DRV_BOUNDS_CHECK_EN
    tests++; if ({req_ready, mem_ce_o} !== 2'b10) begin fails++; $display("FAIL oob_pins got rdy=%b ce=%b exp 1 0", req_ready, mem_ce_o); end
`else
    tests++; if ({req_ready, mem_ce_o, mem_addr_o} !== {2'b11, 5'd5}) begin fails++; $display("FAIL oob_pins got rdy=%b ce=%b addr=%0d exp 1 1 5", req_ready, mem_ce_o, mem_addr_o); end
`endif
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #1;
`ifdef SDQ_DRV_BOUNDS_CHECK_EN
    tests++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 16'h0000, 1'b1}) begin fails++; $display("FAIL oob_rsp got v=%b d=%h e=%b exp 1 0000 1", rsp_valid, rsp_rdata, rsp_err); end
`else
    tests++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 16'h5555, 1'b0}) begin fails++; $display("FAIL oob_rsp got v=%b d=%h e=%b exp 1 5555 0", rsp_valid, rsp_rdata, rsp_err); end
`endif
    @(negedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL oob_empty got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    @(negedge clk);
    req_addr = 5'd0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #1;
    tests++; if ({rsp_valid, req_ready} !== 2'b10) begin fails++; $display("FAIL rm_full got v=%b rdy=%b exp 1 0", rsp_valid, req_ready); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({rsp_valid, init_done, req_ready, mem_ce_o} !== 4'b0) begin fails++; $display("FAIL rm_drop got v=%b done=%b rdy=%b ce=%b exp 0000", rsp_valid, init_done, req_ready, mem_ce_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if ({mem_we_o, mem_addr_o} !== {1'b1, 5'd0}) begin fails++; $display("FAIL rm_init0 got we=%b addr=%0d exp 1 0", mem_we_o, mem_addr_o); end
    @(negedge clk); #1;
    tests++; if ({mem_we_o, mem_addr_o} !== {1'b1, 5'd1}) begin fails++; $display("FAIL rm_init1 got we=%b addr=%0d exp 1 1", mem_we_o, mem_addr_o); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++; if ({rsp_valid, init_done} !== 2'b01) begin fails++; $display("FAIL rm_stale%0d got v=%b done=%b exp 0 1", i, rsp_valid, init_done); end
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk); #1;
    tests++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL rm_recleared got v=%b d=%h exp 1 0000", rsp_valid, rsp_rdata); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_oob();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdq_req_driver.md
# sdq_req_driver

Initiator-side controller for the single-port synchronous SDQ SRAM macros. It sits between a valid/ready request stream and the raw memory pins. After reset it clears the whole array, then issues reads and writes to the macro. Read data is returned on a backpressured response stream with full one-access-per-cycle throughput.

## Interface
- BITS, 16, data word width; must match the attached macro.
- WORD_DEPTH, 2, number of implemented words in the macro.
- ADDR_WIDTH, 5, address width of the macro.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  BITS  write data.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
- rsp_rdata  out  BITS  read data.
- rsp_err  out  1  response is for an out-of-range address (see Configuration).
- init_done  out  1  array clear finished; requests allowed.
- mem_addr_o  out  ADDR_WIDTH  to macro addr_in.
- mem_we_o  out  1  to macro we_in.
- mem_wd_o  out  BITS  to macro wd_in.
- mem_ce_o  out  1  to macro ce_in.
- mem_rd_i  in  BITS  from macro rd_out.

## Operation
- FSM states INIT and RUN. Reset enters INIT with the clear counter at 0.
- INIT:
  - Drives mem_ce_o=1, mem_we_o=1, mem_wd_o=0, mem_addr_o=counter.
  - The counter increments each cycle.
  - After address WORD_DEPTH-1 is written, the FSM moves to RUN.
  - INIT lasts exactly WORD_DEPTH cycles. req_ready=0 throughout.
- RUN: init_done=1. Memory pins are combinational from the accepted request: accept = req_valid && req_ready.
  - mem_ce_o = accept.
  - mem_we_o = accept && req_we.
  - mem_addr_o = req_addr.
  - mem_wd_o = req_wdata.
  - When no request is accepted, mem_we_o=0, mem_ce_o=0, and address/data are don't-care.
- Writes produce no response.
- An accepted read sets rd_inflight for one cycle. On the next cycle, mem_rd_i is pushed into a 2-entry response FIFO.
  - The macro updates rd_out every edge, so mem_rd_i is sampled only in that cycle.
- Credit rule: req_ready = RUN && (fifo_count + rd_inflight - pop) < 2, where pop = rsp_valid && rsp_ready.
  - The FIFO can never overflow.
  - A write needs no credit but still obeys req_ready.
- Ordering: responses are returned in read-issue order.
  - A read issued the cycle after a write to the same address returns the new data.
- FIFO pointers wrap modulo 2. A simultaneous push and pop keeps the count unchanged.
- An asynchronous reset mid-operation drops all in-flight and queued responses and restarts INIT.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - mem_we_o=0, mem_ce_o=0, mem_addr_o=0, mem_wd_o=0.
- After rst_n rises, the first INIT write is on the first edge. init_done rises WORD_DEPTH cycles later.
- Read accepted at edge T: the macro samples at T, data is captured into the FIFO at T+1, and rsp_valid=1 after T+1 (2-cycle latency).
- With rsp_ready held at 1, a read can be accepted every cycle.
- rsp_valid/rsp_rdata/rsp_err hold stable while rsp_valid && !rsp_ready.

## Configuration
- SDQ_DRV_BOUNDS_CHECK_EN defined:
  - A request with req_addr >= WORD_DEPTH is accepted but not forwarded: mem_ce_o=0, mem_we_o=0.
  - Such a read still consumes a credit and returns rsp_rdata=0, rsp_err=1 in its ordered slot.
  - Such a write is silently dropped.
- Not defined:
  - All addresses are forwarded to the macro unchanged.
  - rsp_err is tied to 0.

## Test plan
- Reset release with WORD_DEPTH=2 -> two cycles of mem_we_o=1, mem_wd_o=0 at addresses 0 and 1; init_done=1 on the third cycle; req_ready=0 before that.
- Write 0xBEEF to addr 1, then read addr 1 on the next cycle -> single response 0xBEEF, rsp_err=0, rsp_valid two cycles after the read was accepted.
- Back-to-back reads of addr 0 then addr 1 with rsp_ready=1 -> req_ready stays 1; responses arrive in order on consecutive cycles.
- Hold rsp_ready=0 and issue 3 reads -> 2 accepted; req_ready=0 until one response is popped; the held response is stable.
- With SDQ_DRV_BOUNDS_CHECK_EN, read addr 5 -> mem_ce_o=0; response rsp_rdata=0, rsp_err=1. Without the macro -> mem_ce_o=1, mem_addr_o=5, rsp_err=0.
- Assert rst_n low with 2 responses queued -> rsp_valid drops immediately; INIT replays; no stale response appears afterwards.
